// File: rtl/bf_pkg.sv
// Opcode and FSM state definitions shared by the BF interpreter core and its helpers.
package bf_pkg;

    localparam int unsigned OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP   = 4'h0,
        OP_INC   = 4'h1,
        OP_DEC   = 4'h2,
        OP_RIGHT = 4'h3,
        OP_LEFT  = 4'h4,
        OP_LOOP  = 4'h5,
        OP_END   = 4'h6,
        OP_OUT   = 4'h7,
        OP_IN    = 4'h8,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_SKIP_F,
        S_SKIP_E,
        S_OUT_W,
        S_IN_W,
        S_HALT,
        S_ERROR
    } state_e;

endpackage

// File: rtl/bf_loop_stack.sv
// LIFO of loop-body return addresses; top is readable without popping.
module bf_loop_stack #(
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned WIDTH       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mem [STACK_DEPTH];
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_top_idx;

    assign w_wr_idx  = r_count[PTR_W-1:0];
    assign w_top_idx = r_count[PTR_W-1:0] - PTR_W'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_full    = (r_count == CNT_W'(STACK_DEPTH));
    assign o_empty   = (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_count <= r_count + CNT_W'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/bf_core.sv
// BF interpreter: two-cycle fetch/execute over registered program and data memories,
// with a hardware loop stack and valid/ready byte streams for '.' and ','.
module bf_core
    import bf_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [PC_WIDTH-1:0]   pc,
    input  logic [OPCODE_W-1:0]   prg,
    output logic [ADDR_WIDTH-1:0] cursor,
    input  logic [DATA_WIDTH-1:0] mem,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  i_ready,
    output logic                  halt,
    output logic                  error
);

    state_e                r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0] r_cursor;
    logic [PC_WIDTH-1:0]   r_depth;
    logic [DATA_WIDTH-1:0] r_o_data;
    logic                  r_o_valid;
    logic                  r_i_ready;
    logic                  r_halt;
    logic                  r_error;

    logic [PC_WIDTH-1:0]   w_pc_inc;
    logic                  w_pc_wrap;
    logic                  w_mem_zero;
    logic                  w_exec;
    logic                  w_push;
    logic                  w_pop;
    logic [PC_WIDTH-1:0]   w_top;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_out;

    assign w_pc_inc   = r_pc + PC_WIDTH'(1);
    assign w_pc_wrap  = (w_pc_inc == '0);
    assign w_mem_zero = (mem == '0);
    assign w_exec     = (r_state == S_EXEC) && !rst;
    assign w_push     = w_exec && (prg == OP_LOOP) && !w_mem_zero && !w_full;
    assign w_pop      = w_exec && (prg == OP_END) && w_mem_zero && !w_empty;

    bf_loop_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .WIDTH       (PC_WIDTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Write port is combinational so the cell read in EXEC is updated in that same cycle.
    always_comb begin
        w_we  = 1'b0;
        w_out = '0;
        if (!rst) begin
            if (r_state == S_EXEC && prg == OP_INC) begin
                w_we  = 1'b1;
                w_out = mem + DATA_WIDTH'(1);
            end else if (r_state == S_EXEC && prg == OP_DEC) begin
                w_we  = 1'b1;
                w_out = mem - DATA_WIDTH'(1);
            end else if (r_state == S_IN_W && i_valid) begin
                w_we  = 1'b1;
                w_out = i_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_cursor  <= '0;
            r_depth   <= '0;
            r_o_data  <= '0;
            r_o_valid <= 1'b0;
            r_i_ready <= 1'b0;
            r_halt    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_EXEC;

                // Default is advance-and-fetch; stalling/terminal opcodes re-hold r_pc.
                S_EXEC: begin
                    r_state <= S_FETCH;
                    r_pc    <= w_pc_inc;
                    case (prg)
                        OP_RIGHT: r_cursor <= r_cursor + ADDR_WIDTH'(1);
                        OP_LEFT:  r_cursor <= r_cursor - ADDR_WIDTH'(1);
                        OP_LOOP: begin
                            if (!w_mem_zero) begin
                                if (w_full) begin
                                    r_pc    <= r_pc;
                                    r_state <= S_ERROR;
                                    r_error <= 1'b1;
                                end
                            end else if (w_pc_wrap) begin
                                r_pc    <= r_pc;
                                r_state <= S_ERROR;
                                r_error <= 1'b1;
                            end else begin
                                r_depth <= PC_WIDTH'(1);
                                r_state <= S_SKIP_F;
                            end
                        end
                        OP_END: begin
                            if (w_empty) begin
                                r_pc    <= r_pc;
                                r_state <= S_ERROR;
                                r_error <= 1'b1;
                            end else if (!w_mem_zero) begin
                                r_pc <= w_top;
                            end
                        end
                        OP_OUT: begin
                            r_pc      <= r_pc;
                            r_o_data  <= mem;
                            r_o_valid <= 1'b1;
                            r_state   <= S_OUT_W;
                        end
                        OP_IN: begin
                            r_pc      <= r_pc;
                            r_i_ready <= 1'b1;
                            r_state   <= S_IN_W;
                        end
                        OP_HALT: begin
                            r_pc    <= r_pc;
                            r_halt  <= 1'b1;
                            r_state <= S_HALT;
                        end
                        default: ;
                    endcase
                end

                S_SKIP_F: r_state <= S_SKIP_E;

                S_SKIP_E: begin
                    if ((prg == OP_LOOP && r_depth == '1) || w_pc_wrap) begin
                        r_state <= S_ERROR;
                        r_error <= 1'b1;
                    end else begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_SKIP_F;
                        if (prg == OP_LOOP) begin
                            r_depth <= r_depth + PC_WIDTH'(1);
                        end else if (prg == OP_END) begin
                            r_depth <= r_depth - PC_WIDTH'(1);
                            if (r_depth == PC_WIDTH'(1)) begin
                                r_state <= S_FETCH;
                            end
                        end
                    end
                end

                S_OUT_W: begin
                    if (o_ready) begin
                        r_o_valid <= 1'b0;
                        r_pc      <= w_pc_inc;
                        r_state   <= S_FETCH;
                    end
                end

                S_IN_W: begin
                    if (i_valid) begin
                        r_i_ready <= 1'b0;
                        r_pc      <= w_pc_inc;
                        r_state   <= S_FETCH;
                    end
                end

                S_HALT:  ;
                S_ERROR: ;
                default: ;
            endcase
        end
    end

    assign pc      = r_pc;
    assign cursor  = r_cursor;
    assign out     = w_out;
    assign we      = w_we;
    assign o_data  = r_o_data;
    assign o_valid = r_o_valid;
    assign i_ready = r_i_ready;
    assign halt    = r_halt;
    assign error   = r_error;

endmodule
